// File: rtl/bias_group_seq_l9_if.sv
// Handshake/bus bundle between the layer-9 bias sequencer and its neighbours.
// L9_PERF_CNT_EN adds the cycle_cnt_o performance counter output.
interface bias_group_seq_l9_if #(
   parameter int W = 288
);
   logic         start_i;
   logic         tile_valid_i;
   logic         out_ready_i;
   logic [W-1:0] bias_in_i;
   logic [2:0]   z_o;
   logic [W-1:0] bias_q_o;
   logic         bias_vld_o;
   logic         acc_clr_o;
   logic         busy_o;
   logic         done_o;
`ifdef L9_PERF_CNT_EN
   logic [31:0]  cycle_cnt_o;

   modport master (
      output start_i, tile_valid_i, out_ready_i, bias_in_i,
      input  z_o, bias_q_o, bias_vld_o, acc_clr_o, busy_o, done_o, cycle_cnt_o
   );
   modport slave (
      input  start_i, tile_valid_i, out_ready_i, bias_in_i,
      output z_o, bias_q_o, bias_vld_o, acc_clr_o, busy_o, done_o, cycle_cnt_o
   );
`else
   modport master (
      output start_i, tile_valid_i, out_ready_i, bias_in_i,
      input  z_o, bias_q_o, bias_vld_o, acc_clr_o, busy_o, done_o
   );
   modport slave (
      input  start_i, tile_valid_i, out_ready_i, bias_in_i,
      output z_o, bias_q_o, bias_vld_o, acc_clr_o, busy_o, done_o
   );
`endif
endinterface

// File: rtl/bias_group_seq_l9.sv
// Layer-9 bias group sequencer: steps the 8:1 bias mux, counts adder-tree tiles per group
// and hands each captured bias word to the output stage. L9_PERF_CNT_EN adds cycle_cnt_o.
module bias_group_seq_l9 #(
   parameter int N_adder_tree = 16,
   parameter int N_TILES      = 9,
   parameter int N_GROUPS     = 8
) (
   input  logic              clk,
   input  logic              rst,
   bias_group_seq_l9_if.slave bus
);
   localparam int W   = N_adder_tree * 18;
   localparam int TCW = (N_TILES > 1) ? $clog2(N_TILES) : 1;
   localparam logic [TCW-1:0] TILE_LAST = TCW'(N_TILES - 1);
   localparam logic [2:0]     GRP_LAST  = 3'(N_GROUPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_ACCUM,
      S_BIAS,
      S_DONE
   } state_t;

   state_t         state_q;
   logic [2:0]     grp_q;
   logic [TCW-1:0] tile_cnt_q;
   logic [W-1:0]   bias_word_q;
   logic           bias_vld_q;
   logic           acc_clr_q;
   logic           busy_q;
   logic           done_q;

   // All outputs are registered; grp_q doubles as the mux select so z never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         grp_q       <= '0;
         tile_cnt_q  <= '0;
         bias_word_q <= '0;
         bias_vld_q  <= 1'b0;
         acc_clr_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the
         // pre-edge values; the pulse outputs default low and are re-armed per state.
         acc_clr_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  state_q    <= S_SEL;
                  grp_q      <= '0;
                  tile_cnt_q <= '0;
                  acc_clr_q  <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_SEL: begin
               // z has been stable for this whole cycle, so the mux output is settled.
               bias_word_q <= bus.bias_in_i;
               state_q     <= S_ACCUM;
            end
            S_ACCUM: begin
               if (bus.tile_valid_i) begin
                  if (tile_cnt_q == TILE_LAST) begin
                     tile_cnt_q <= '0;
                     bias_vld_q <= 1'b1;
                     state_q    <= S_BIAS;
                  end else begin
                     tile_cnt_q <= tile_cnt_q + 1'b1;
                  end
               end
            end
            S_BIAS: begin
               if (bus.out_ready_i) begin
                  bias_vld_q <= 1'b0;
                  if (grp_q == GRP_LAST) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     grp_q     <= grp_q + 3'd1;
                     acc_clr_q <= 1'b1;
                     state_q   <= S_SEL;
                  end
               end
            end
            S_DONE: begin
               grp_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.z_o        = grp_q;
   assign bus.bias_q_o   = bias_word_q;
   assign bus.bias_vld_o = bias_vld_q;
   assign bus.acc_clr_o  = acc_clr_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;

`ifdef L9_PERF_CNT_EN
   logic        start_acc;
   logic [31:0] cyc_cnt_q;
   logic [31:0] cyc_cnt_d;

   assign start_acc = (state_q == S_IDLE) && bus.start_i;

   // The accepting cycle reads 0 and counts as the first cycle of the pass.
   always_comb begin
      // NOTE: default first so no path leaves cyc_cnt_d unassigned (no latch).
      cyc_cnt_d = cyc_cnt_q;
      if (start_acc) begin
         cyc_cnt_d = 32'd1;
      end else if (busy_q && (cyc_cnt_q != 32'hFFFF_FFFF)) begin
         cyc_cnt_d = cyc_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt_q <= '0;
      end else begin
         cyc_cnt_q <= cyc_cnt_d;
      end
   end

   assign bus.cycle_cnt_o = start_acc ? 32'd0 : cyc_cnt_q;
`endif

endmodule

// File: tb/tb_bias_group_seq_l9.sv
// Self-checking bench for bias_group_seq_l9: pass-level reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_bias_group_seq_l9;
   localparam int NA = 16;
   localparam int W  = NA * 18;
   localparam int NT = 9;
   localparam int NG = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bias_group_seq_l9_if #(.W(W)) bus ();

   bias_group_seq_l9 #(
      .N_adder_tree(NA),
      .N_TILES     (NT),
      .N_GROUPS    (NG)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int vecs = 0;
   int miss = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
      return r;
   endfunction

   // Mux emulation: in mux mode the bias word follows the select, else it is random.
   logic [W-1:0] pat [NG];
   logic [W-1:0] rnd_bias;
   bit           mux_mode;
   always_comb bus.bias_in_i = mux_mode ? pat[bus.z_o] : rnd_bias;

   // Pass-level model: where the pass is (selecting, collecting tiles, offering, finishing).
   bit           m_busy, m_sel, m_wait, m_done;
   int           m_grp, m_tiles;
   logic [W-1:0] m_bias;

   task automatic model_reset();
      m_busy = 0; m_sel = 0; m_wait = 0; m_done = 0;
      m_grp = 0; m_tiles = 0; m_bias = '0;
   endtask

   task automatic model_step();
      if (m_done) begin
         m_done = 0; m_busy = 0; m_grp = 0;
      end else if (!m_busy) begin
         if (bus.start_i) begin
            m_busy = 1; m_sel = 1; m_grp = 0; m_tiles = 0;
         end
      end else if (m_sel) begin
         m_bias = bus.bias_in_i;
         m_sel  = 0;
      end else if (m_wait) begin
         if (bus.out_ready_i) begin
            m_wait = 0;
            if (m_grp == NG - 1) m_done = 1;
            else begin
               m_grp++; m_sel = 1;
            end
         end
      end else if (bus.tile_valid_i) begin
         m_tiles++;
         if (m_tiles == NT) begin
            m_tiles = 0; m_wait = 1;
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   bit cmp_en = 0;
   always @(negedge clk) begin
      if (!rst && cmp_en) begin
         check("z",        W'(bus.z_o),        W'(m_grp[2:0]));
         check("busy",     W'(bus.busy_o),     W'(m_busy));
         check("acc_clr",  W'(bus.acc_clr_o),  W'(m_sel));
         check("bias_vld", W'(bus.bias_vld_o), W'(m_wait));
         check("done",     W'(bus.done_o),     W'(m_done));
         check("bias_q",   bus.bias_q_o,       m_bias);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_z"},        W'(bus.z_o),        '0);
      check({tag, "_bias_q"},   bus.bias_q_o,       '0);
      check({tag, "_bias_vld"}, W'(bus.bias_vld_o), '0);
      check({tag, "_acc_clr"},  W'(bus.acc_clr_o),  '0);
      check({tag, "_busy"},     W'(bus.busy_o),     '0);
      check({tag, "_done"},     W'(bus.done_o),     '0);
   endtask

   int cyc, n_clr, n_xfer, n_vld2, hold, passes;
   bit seen_done, waited;

   initial begin
      rst = 1'b1;
      mux_mode = 1'b1;
      rnd_bias = '0;
      bus.start_i = 0; bus.tile_valid_i = 0; bus.out_ready_i = 0;
      for (int i = 0; i < NG; i++) pat[i] = rnd_word();
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("por");
      cmp_en = 1;

      // Tied-high pass; start also raised in group-1 ACCUM and on the done cycle.
      tick();
      bus.tile_valid_i = 1; bus.out_ready_i = 1; bus.start_i = 1;
      tick();
      bus.start_i = 0;
      cyc = 2; n_clr = 0; n_xfer = 0; seen_done = 0;
      for (int k = 0; k < 200 && !seen_done; k++) begin
         @(negedge clk);
         if (bus.acc_clr_o) n_clr++;
         if (bus.bias_vld_o) begin
            check("xfer_z", W'(bus.z_o), W'(n_xfer));
            check("xfer_bias", bus.bias_q_o, pat[n_xfer[2:0]]);
            n_xfer++;
         end
         if (bus.done_o) begin
            seen_done = 1;
            check("done_cycle", W'(cyc), W'(90));
         end else cyc++;
         @(posedge clk); #1;
         bus.start_i = bus.done_o ||
                       (bus.busy_o && bus.z_o == 3'd1 && !bus.acc_clr_o && !bus.bias_vld_o);
      end
      check("pass_done_seen", W'(seen_done), W'(1));
      check("acc_clr_count", W'(n_clr), W'(NG));
      check("xfer_count", W'(n_xfer), W'(NG));
      bus.start_i = 0;
      @(negedge clk);
      check("busy_after_done", W'(bus.busy_o), '0);
`ifdef L9_PERF_CNT_EN
      check("cycle_cnt_hold", W'(bus.cycle_cnt_o), W'(90));
`endif

      // Output stage stalls 5 cycles while group 2 is offered.
      for (int i = 0; i < NG; i++) pat[i] = rnd_word();
      tick();
      bus.start_i = 1;
`ifdef L9_PERF_CNT_EN
      @(negedge clk);
      check("cycle_cnt_clear", W'(bus.cycle_cnt_o), '0);
`endif
      tick();
      bus.start_i = 0;
      hold = 0; n_vld2 = 0; seen_done = 0;
      for (int k = 0; k < 300 && !seen_done; k++) begin
         if (bus.bias_vld_o && bus.z_o == 3'd2 && hold < 5) begin
            bus.out_ready_i = 0; hold++;
         end else bus.out_ready_i = 1;
         @(negedge clk);
         if (bus.bias_vld_o && bus.z_o == 3'd2) begin
            n_vld2++;
            check("stall_bias", bus.bias_q_o, pat[2]);
         end
         seen_done = bus.done_o;
         @(posedge clk); #1;
      end
      check("stall_done_seen", W'(seen_done), W'(1));
      check("stall_vld_cycles", W'(n_vld2), W'(6));
      bus.out_ready_i = 1;

      // Reset in the middle of group-3 accumulation, then restart.
      tick();
      bus.start_i = 1;
      tick();
      bus.start_i = 0;
      waited = 0;
      for (int k = 0; k < 200 && !waited; k++) begin
         if (bus.busy_o && bus.z_o == 3'd3 && !bus.acc_clr_o && !bus.bias_vld_o) waited = 1;
         else tick();
      end
      check("reach_grp3_accum", W'(waited), W'(1));
      #2 rst = 1'b1;
      #1 check_reset_outputs("mid_rst");
      @(posedge clk);
      #2 rst = 1'b0;
      tick();
      bus.start_i = 1;
      tick();
      bus.start_i = 0;
      @(negedge clk);
      check("restart_z", W'(bus.z_o), '0);
      check("restart_acc_clr", W'(bus.acc_clr_o), W'(1));

      // Random traffic: stray tile_valid/start everywhere, random back-pressure and bias.
      mux_mode = 0;
      passes = 0;
      for (int k = 0; k < 6000 && passes < 5; k++) begin
         tick();
         bus.start_i      = ($urandom_range(3) == 0);
         bus.tile_valid_i = ($urandom_range(1) == 1);
         bus.out_ready_i  = ($urandom_range(2) != 0);
         rnd_bias         = rnd_word();
         @(negedge clk);
         if (bus.done_o) passes++;
      end
      check("random_passes", W'(passes), W'(5));

      tick();
      cmp_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
